mio_bus_arbiter: RTL and testbench

- Two-master, one-slave memory-bus arbiter with a transaction sequencer.
- Shares the single memory/IO port between the multicycle CPU (master 0: CPU_MIO-style request, Addr_out, Data_out, mem_w) and a secondary master (master 1: DMA/peripheral).
- Returns the per-master ready handshake that the CPU consumes as MIO_ready.
- Serialises transactions, captures read data and bounds slave latency with a timeout.

---
 rtl/mio_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter.sv
// Two-master, one-slave memory bus arbiter with transaction sequencer and slave timeout.
// Define MIO_ARB_FIXED_PRIO_EN for fixed m0 priority; default build is round-robin.
module mio_bus_arbiter #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 15,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t     state, next_state;
  logic       owner;
  logic [7:0] counter;
  logic [7:0] cnt_inc;
  logic       req_any;
  logic       pick_m1;
  logic       timed_out;

`ifndef MIO_ARB_FIXED_PRIO_EN
  logic       last_owner;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Owner selection: a lone requester always wins; contention is resolved by policy.
  always_comb begin
    next_state = state;
    req_any    = m0_req | m1_req;
    cnt_inc    = counter + 8'd1;
    timed_out  = (cnt_inc >= TO_LIMIT);
`ifdef MIO_ARB_FIXED_PRIO_EN
    pick_m1    = ~m0_req & m1_req;
`else
    pick_m1    = m1_req & (~m0_req | ~last_owner);
`endif
    case (state)
      IDLE:    if (req_any) next_state = XFER;
      XFER:    if (mem_ack || timed_out) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner       <= 1'b0;
      counter     <= 8'd0;
      grant       <= 2'b00;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      timeout_err <= 1'b0;
`ifndef MIO_ARB_FIXED_PRIO_EN
      last_owner  <= 1'b1;
`endif
    end else begin
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            owner     <= pick_m1;
            grant     <= pick_m1 ? 2'b10 : 2'b01;
            mem_req   <= 1'b1;
            mem_we    <= pick_m1 ? m1_we    : m0_we;
            mem_addr  <= pick_m1 ? m1_addr  : m0_addr;
            mem_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            counter   <= 8'd0;
          end
        end
        // An ack in the final allowed cycle still counts as a normal completion.
        XFER: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (owner) begin
              m1_rdata <= mem_rdata;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= mem_rdata;
              m0_ready <= 1'b1;
            end
          end else if (timed_out) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            if (owner) begin
              m1_rdata <= ERR_DATA;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= ERR_DATA;
              m0_ready <= 1'b1;
            end
          end else begin
            counter <= cnt_inc;
          end
        end
        DONE: begin
          grant   <= 2'b00;
          counter <= 8'd0;
`ifndef MIO_ARB_FIXED_PRIO_EN
          last_owner <= owner;
`endif
        end
        default: begin
          grant   <= 2'b00;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Scoreboard bench for mio_bus_arbiter: expected completions are queued at issue
// and checked against each ready pulse.
module tb_mio_bus_arbiter;

  localparam logic [31:0] KEY     = 32'h5A5A0000;
  localparam logic [31:0] ERRWORD = 32'hDEADBEEF;
`ifdef MIO_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  logic        addrData;
  logic [31:0] fixedData;

  typedef struct packed {
    logic        m;
    logic [31:0] data;
    logic        terr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mio_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Slave model: either a fixed word or an address-derived word.
  always_comb begin
    mem_rdata = fixedData;
    if (addrData) mem_rdata = mem_addr ^ KEY;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (m0_ready || m1_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("ready_owner", {30'd0, m1_ready, m0_ready}, e.m ? 32'd2 : 32'd1);
        checkOutput("rdata", e.m ? m1_rdata : m0_rdata, e.data);
        checkOutput("timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
      end
    end else if (timeout_err) begin
      checkOutput("terr_without_ready", 32'd1, 32'd0);
    end
  end

  task automatic applyStimulus(input logic m, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input logic expTerr, output int xferCycles,
                               output logic [31:0] seenAddr);
    bit done;
    sb.push_back('{m: m, data: expData, terr: expTerr});
    @(negedge clk);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    xferCycles = 0;
    seenAddr   = '0;
    done       = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (mem_req) begin
        xferCycles++;
        seenAddr = mem_addr;
      end
      if (m ? m1_ready : m0_ready) done = 1'b1;
    end
    if (!done) checkOutput("txn_wait_expired", 32'd0, 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] a;
    logic [1:0]  expGrant;
    int          j;

    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    mem_ack = 1'b0; addrData = 1'b0; fixedData = 32'h01285020;
    repeat (2) @(negedge clk);
    checkOutput("rst_grant", {30'd0, grant}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'd0);
    checkOutput("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    checkOutput("rst_terr", {31'd0, timeout_err}, 32'd0);
    reset = 1'b1;

    $display("[TB] single read");
    mem_ack = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h8, 32'h0, 32'h01285020, 1'b0, n, a);
    checkOutput("single_xfer_cycles", n, 32'd1);
    checkOutput("single_mem_addr", a, 32'h8);
    @(negedge clk);
    checkOutput("single_grant_idle", {30'd0, grant}, 32'd0);

    $display("[TB] contention");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    addrData = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (FIXED || (t % 2 == 0)) sb.push_back('{m: 1'b0, data: 32'h100 ^ KEY, terr: 1'b0});
      else                        sb.push_back('{m: 1'b1, data: 32'h200 ^ KEY, terr: 1'b0});
    end
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      j = (k - 1) / 3;
      if ((k % 3) == 0)              expGrant = 2'b00;
      else if (FIXED || (j % 2 == 0)) expGrant = 2'b01;
      else                           expGrant = 2'b10;
      checkOutput("contention_grant", {30'd0, grant}, {30'd0, expGrant});
    end
    m0_req = 1'b0;
    m1_req = 1'b0;

    $display("[TB] wait states");
    addrData = 1'b0; fixedData = 32'h0BADF00D; mem_ack = 1'b0;
    sb.push_back('{m: 1'b1, data: 32'h0BADF00D, terr: 1'b0});
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h0000000A;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("ws_req_we", {30'd0, mem_req, mem_we}, 32'd3);
      checkOutput("ws_addr", mem_addr, 32'h40);
      checkOutput("ws_wdata", mem_wdata, 32'h0000000A);
      if (c == 4) mem_ack = 1'b1;
    end
    @(negedge clk);
    m1_req = 1'b0;
    mem_ack = 1'b0;
    checkOutput("ws_m0_rdata_hold", m0_rdata, 32'h100 ^ KEY);

    $display("[TB] timeout");
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, ERRWORD, 1'b1, n, a);
    checkOutput("to_xfer_cycles", n, 32'd15);
    mem_ack = 1'b1; addrData = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h24, 32'h0, 32'h24 ^ KEY, 1'b0, n, a);
    checkOutput("after_to_xfer_cycles", n, 32'd1);

    $display("[TB] reset mid transfer");
    mem_ack = 1'b0;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
    @(negedge clk);
    checkOutput("mid_mem_req_before", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("mid_grant", {30'd0, grant}, 32'd0);
    checkOutput("mid_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    checkOutput("mid_m0_rdata", m0_rdata, 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1;
    sb.push_back('{m: 1'b0, data: 32'h8 ^ KEY, terr: 1'b0});
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h8;
    m1_req = 1'b1; m1_addr = 32'h44;
    @(negedge clk);
    checkOutput("post_rst_grant", {30'd0, grant}, 32'd1);
    m1_req = 1'b0;
    @(negedge clk);
    m0_req = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", {30'd0, grant}, 32'd0);

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
